instruction_fetch_unit: RTL and testbench

Fetch stage of the MIPS pipeline. Acts as the initiator of the instruction-memory read interface.
- Owns the PC and drives the word-aligned fetch address.
- Takes the combinational instruction word returned by instruction memory.
- Registers it with PC+4 into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from later stages, and traps misaligned redirect targets.

---
 rtl/instruction_fetch_unit_pkg.sv | 25 ++
 rtl/if_id_register.sv | 52 +++++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instruction_fetch_unit_pkg : shared fetch-stage state encoding and constants
// Rev 1.0
// ----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS_DEFAULT = 512;

  function automatic logic [31:0] imem_byte_limit(input int unsigned words);
    return 32'(words * 4);
  endfunction

  localparam logic [31:0] IMEM_BYTE_LIMIT = imem_byte_limit(IMEM_WORDS_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_id_register : IF/ID pipeline register with bubble > hold > load priority
// Rev 1.0
// ----------------------------------------------------------------------------
module if_id_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic        hold_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pcplus4_q;
  logic        valid_q;

  // A bubble leaves pcplus4 alone; only valid and the opcode slot matter downstream.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      instr_q   <= NOP_WORD;
      pcplus4_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else if (bubble_i) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (hold_i) begin
      instr_q   <= instr_q;
      pcplus4_q <= pcplus4_q;
      valid_q   <= valid_q;
    end else if (load_i) begin
      instr_q   <= instruction_i;
      pcplus4_q <= pcplus4_i;
      valid_q   <= 1'b1;
    end
  end

  assign instruction_o = instr_q;
  assign pcplus4_o     = pcplus4_q;
  assign valid_o       = valid_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instruction_fetch_unit : MIPS fetch stage - PC, BOOT/RUN/FAULT FSM, IF/ID feed
// Rev 1.0
// ----------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] PC,
  output logic [31:0] IfId_Instruction,
  output logic [31:0] IfId_PCPlus4,
  output logic        IfId_Valid,
  output logic        AddrFault
);

  localparam logic [31:0] IMEM_LIMIT = imem_byte_limit(IMEM_WORDS);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;

  logic [31:0]  pc_plus4;
  logic         in_range;
  logic         ctl_load;
  logic         ctl_bubble;
  logic         ctl_hold;

  assign pc_plus4 = pc_q + 32'd4;
  assign in_range = (pc_q < IMEM_LIMIT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    ctl_load   = 1'b0;
    ctl_bubble = 1'b0;
    ctl_hold   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d  = ST_RUN;
        ctl_hold = 1'b1;
      end
      ST_RUN: begin
        if (RedirectValid) begin
          ctl_bubble = 1'b1;
          if (|RedirectTarget[1:0]) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            pc_d    = {RedirectTarget[31:2], 2'b00};
          end else begin
            pc_d = RedirectTarget;
          end
        end else if (Flush) begin
          ctl_bubble = 1'b1;
          if (!Stall) pc_d = pc_plus4;
        end else if (Stall) begin
          ctl_hold = 1'b1;
        end else begin
          // Running off the end of imem keeps fetching, just without valid words.
          pc_d       = pc_plus4;
          ctl_load   = in_range;
          ctl_bubble = !in_range;
        end
      end
      ST_FAULT: begin
        ctl_bubble = 1'b1;
      end
      default: begin
        state_d    = ST_FAULT;
        ctl_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_BOOT;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .Clk           (Clk),
    .Reset         (Reset),
    .load_i        (ctl_load),
    .bubble_i      (ctl_bubble),
    .hold_i        (ctl_hold),
    .instruction_i (ImemInstruction),
    .pcplus4_i     (pc_plus4),
    .instruction_o (IfId_Instruction),
    .pcplus4_o     (IfId_PCPlus4),
    .valid_o       (IfId_Valid)
  );

  assign ImemAddress = pc_q;
  assign PC          = pc_q;
  assign AddrFault   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit : directed scoreboard bench for instruction_fetch_unit
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        RedirectValid = 1'b0;
  logic [31:0] RedirectTarget = 32'h0;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic [31:0] PC;
  logic [31:0] IfId_Instruction;
  logic [31:0] IfId_PCPlus4;
  logic        IfId_Valid;
  logic        AddrFault;

  int n_asserts = 0;
  int n_fails   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    bit          chk_p4;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t sb[$];

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (512),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Stall            (Stall),
    .Flush            (Flush),
    .RedirectValid    (RedirectValid),
    .RedirectTarget   (RedirectTarget),
    .ImemAddress      (ImemAddress),
    .ImemInstruction  (ImemInstruction),
    .PC               (PC),
    .IfId_Instruction (IfId_Instruction),
    .IfId_PCPlus4     (IfId_PCPlus4),
    .IfId_Valid       (IfId_Valid),
    .AddrFault        (AddrFault)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h200F_FC18;
    if (a == 32'h4) return 32'h01E0_7801;
    return 32'h2400_0000 | a;
  endfunction

  assign ImemInstruction = mem_word(ImemAddress);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] epc, input logic [31:0] ein,
                      input logic [31:0] ep4, input bit cp4, input logic ev, input logic ef);
    exp_t e;
    e.tag = tag; e.pc = epc; e.instr = ein; e.p4 = ep4;
    e.chk_p4 = cp4; e.valid = ev; e.fault = ef;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    n_asserts++;
    assert (sb.size() != 0) else begin
      n_fails++;
      $error("FAIL scoreboard_empty: observed %0d entries expected >0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},    PC,               e.pc);
      chk({e.tag, ".addr"},  ImemAddress,      e.pc);
      chk({e.tag, ".instr"}, IfId_Instruction, e.instr);
      if (e.chk_p4) chk({e.tag, ".p4"}, IfId_PCPlus4, e.p4);
      chk({e.tag, ".valid"}, {31'b0, IfId_Valid}, {31'b0, e.valid});
      chk({e.tag, ".fault"}, {31'b0, AddrFault},  {31'b0, e.fault});
    end
  endtask

  // Drive one cycle of controls, record what the next edge must produce, then check it.
  task automatic step(input string tag, input bit st, input bit fl, input bit rv,
                      input logic [31:0] tgt, input logic [31:0] epc, input logic [31:0] ein,
                      input logic [31:0] ep4, input bit cp4, input logic ev, input logic ef);
    Stall = st; Flush = fl; RedirectValid = rv; RedirectTarget = tgt;
    push(tag, epc, ein, ep4, cp4, ev, ef);
    @(posedge Clk);
    #1;
    compare_front();
  endtask

  initial begin
    #1 Reset = 1'b0;
    #1;
    push("reset_async", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    compare_front();
    @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;

    step("boot",    0,0,0, 32'h0, 32'h0,   32'h0,           32'h0,   1, 0, 0);
    step("fetch0",  0,0,0, 32'h0, 32'h4,   32'h200F_FC18,   32'h4,   1, 1, 0);
    step("fetch4",  0,0,0, 32'h0, 32'h8,   32'h01E0_7801,   32'h8,   1, 1, 0);
    step("stall1",  1,0,0, 32'h0, 32'h8,   32'h01E0_7801,   32'h8,   1, 1, 0);
    step("stall2",  1,0,0, 32'h0, 32'h8,   32'h01E0_7801,   32'h8,   1, 1, 0);
    step("fetch8",  0,0,0, 32'h0, 32'hC,   mem_word(32'h8), 32'hC,   1, 1, 0);
    step("redir40", 1,1,1, 32'h40, 32'h40, 32'h0,           32'h0,   0, 0, 0);
    step("fetch40", 0,0,0, 32'h0, 32'h44,  mem_word(32'h40), 32'h44, 1, 1, 0);
    step("flush",   0,1,0, 32'h0, 32'h48,  32'h0,           32'h0,   0, 0, 0);
    step("flushst", 1,1,0, 32'h0, 32'h48,  32'h0,           32'h0,   0, 0, 0);
    step("fetch48", 0,0,0, 32'h0, 32'h4C,  mem_word(32'h48), 32'h4C, 1, 1, 0);

    step("redir7f8", 0,0,1, 32'h7F8, 32'h7F8, 32'h0,            32'h0,  0, 0, 0);
    step("fetch7f8", 0,0,0, 32'h0,   32'h7FC, mem_word(32'h7F8), 32'h7FC, 1, 1, 0);
    step("fetch7fc", 0,0,0, 32'h0,   32'h800, mem_word(32'h7FC), 32'h800, 1, 1, 0);
    step("oor800",   0,0,0, 32'h0,   32'h804, 32'h0,            32'h0,  0, 0, 0);
    step("oor804",   0,0,0, 32'h0,   32'h808, 32'h0,            32'h0,  0, 0, 0);

    step("redirtop", 0,0,1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 0);
    step("wrap",     0,0,0, 32'h0, 32'h0, 32'h0,         32'h0, 0, 0, 0);
    step("afterwrp", 0,0,0, 32'h0, 32'h4, 32'h200F_FC18, 32'h4, 1, 1, 0);

    step("fault42",  0,0,1, 32'h42, 32'h40, 32'h0, 32'h0, 0, 0, 1);
    step("faultidl", 0,0,0, 32'h0,  32'h40, 32'h0, 32'h0, 0, 0, 1);
    step("faultrd",  1,1,1, 32'h80, 32'h40, 32'h0, 32'h0, 0, 0, 1);
    step("faultfr",  0,0,0, 32'h0,  32'h40, 32'h0, 32'h0, 0, 0, 1);

    #2 Reset = 1'b0;
    #1;
    push("reset_fault", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    compare_front();
    Stall = 0; Flush = 0; RedirectValid = 0; RedirectTarget = 32'h0;
    @(negedge Clk) Reset = 1'b1;

    step("boot2",   0,0,0, 32'h0, 32'h0, 32'h0,         32'h0, 1, 0, 0);
    step("fetch0b", 0,0,0, 32'h0, 32'h4, 32'h200F_FC18, 32'h4, 1, 1, 0);
    step("fetch4b", 0,0,0, 32'h0, 32'h8, 32'h01E0_7801, 32'h8, 1, 1, 0);

    RedirectValid = 1'b1; RedirectTarget = 32'h100;
    #2 Reset = 1'b0;
    #1;
    push("reset_redir", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    compare_front();
    @(posedge Clk);
    #1;
    push("reset_held", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    compare_front();
    RedirectValid = 1'b0; RedirectTarget = 32'h0;
    @(negedge Clk) Reset = 1'b1;
    step("boot3",   0,0,0, 32'h0, 32'h0, 32'h0,         32'h0, 1, 0, 0);
    step("fetch0c", 0,0,0, 32'h0, 32'h4, 32'h200F_FC18, 32'h4, 1, 1, 0);

    n_asserts++;
    assert (sb.size() == 0) else begin
      n_fails++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
